// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, result and ALU micro-step signals of the ALU command sequencer
interface alu_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd;
   logic [7:0]  opa;
   logic [7:0]  opb;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_y;
   logic        res_err;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [15:0] alu_op;
   logic [7:0]  alu_y;
   logic        alu_c;

   modport slave (
      input  cmd_valid, cmd, opa, opb, res_ready, alu_y, alu_c,
      output cmd_ready, res_valid, res_y, res_err, alu_a, alu_b, alu_op
   );

   modport master (
      output cmd_valid, cmd, opa, opb, res_ready, alu_y, alu_c,
      input  cmd_ready, res_valid, res_y, res_err, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - sequences 1-3 ALU micro-steps per command and returns the captured result
module alu_cmd_sequencer #(
   parameter bit RESV_ERR = 1'b1,
   parameter bit FAST_RET = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   alu_cmd_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e      state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [3:0]  cmd_q, cmd_d;
   logic [7:0]  opa_q, opa_d;
   logic [7:0]  opb_q, opb_d;
   logic        saved_c_q, saved_c_d;
   logic [7:0]  res_y_q, res_y_d;
   logic        res_err_q, res_err_d;
   logic        cmd_ready;
   logic        accept;

   function automatic logic [1:0] last_step(input logic [3:0] cmd);
      case (cmd)
         4'h9:       last_step = 2'd1;
         4'hA, 4'hB: last_step = 2'd2;
         default:    last_step = 2'd0;
      endcase
   endfunction

   // INC/DEC capture at the add step; the trailing step only restores carry
   function automatic logic result_step(input logic [3:0] cmd, input logic [1:0] step);
      result_step = ((cmd <= 4'h8) && (step == 2'd0)) ||
                    (((cmd == 4'hA) || (cmd == 4'hB)) && (step == 2'd1));
   endfunction

   function automatic logic [15:0] step_word(input logic [3:0] cmd, input logic [1:0] step,
                                             input logic sc);
      logic [15:0] restore;
      restore = sc ? 16'h01C0 : 16'h0180;
      case (cmd)
         4'h0: step_word = 16'h5903;
         4'h1: step_word = 16'h5902;
         4'h2: step_word = 16'h5004;
         4'h3: step_word = 16'h5005;
         4'h4: step_word = 16'h5006;
         4'h5: step_word = 16'h514C;
         4'h6: step_word = 16'h515C;
         4'h7: step_word = 16'h5164;
         4'h8: step_word = 16'h516C;
         4'h9: step_word = (step == 2'd0) ? 16'h01C0 : 16'h5102;
         4'hA: step_word = (step == 2'd0) ? 16'h01C0 : (step == 2'd1) ? 16'h5001 : restore;
         4'hB: step_word = (step == 2'd0) ? 16'h0180 : (step == 2'd1) ? 16'h5000 : restore;
         4'hC: step_word = 16'h0180;
         4'hD: step_word = 16'h01C0;
         4'hE: step_word = 16'h0C00;
         default: step_word = 16'h0000;
      endcase
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         step_q    <= 2'd0;
         cmd_q     <= 4'h0;
         opa_q     <= 8'h00;
         opb_q     <= 8'h00;
         saved_c_q <= 1'b0;
         res_y_q   <= 8'h00;
         res_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         cmd_q     <= cmd_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         saved_c_q <= saved_c_d;
         res_y_q   <= res_y_d;
         res_err_q <= res_err_d;
      end
   end

   assign accept = bus.cmd_valid && cmd_ready;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cmd_d     = cmd_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      saved_c_d = saved_c_q;
      res_y_d   = res_y_q;
      res_err_d = res_err_q;
      case (state_q)
         EXEC: begin
            if (result_step(cmd_q, step_q)) res_y_d = bus.alu_y;
            if (step_q == last_step(cmd_q)) state_d = RESP;
            else step_d = step_q + 2'd1;
         end
         RESP: if (bus.res_ready) state_d = IDLE;
         default: ;
      endcase
      // an accept can also land in the RESP handshake cycle when FAST_RET is set
      if (accept) begin
         cmd_d     = bus.cmd;
         opa_d     = bus.opa;
         opb_d     = bus.opb;
         saved_c_d = bus.alu_c;
         res_y_d   = bus.opa;
         res_err_d = (bus.cmd == 4'hF) && RESV_ERR;
         step_d    = 2'd0;
         state_d   = (bus.cmd == 4'hF) ? RESP : EXEC;
      end
   end

   always_comb begin
      cmd_ready     = (state_q == IDLE) || (FAST_RET && (state_q == RESP) && bus.res_ready);
      bus.cmd_ready = cmd_ready;
      bus.res_valid = (state_q == RESP);
      bus.res_y     = res_y_q;
      bus.res_err   = res_err_q;
      bus.alu_a     = 8'h00;
      bus.alu_b     = 8'h00;
      bus.alu_op    = 16'h0000;
      if (state_q == EXEC) begin
         bus.alu_a  = opa_q;
         bus.alu_b  = ((cmd_q >= 4'h5) && (cmd_q <= 4'h8)) ? 8'hFF : opb_q;
         bus.alu_op = step_word(cmd_q, step_q, saved_c_q);
      end
   end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - bench for alu_cmd_sequencer with an ALU model and a command-level reference
module tb_alu_cmd_sequencer;
   localparam bit U0_RESV = 1'b1, U0_FAST = 1'b0;
   localparam bit U1_RESV = 1'b0, U1_FAST = 1'b1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;
   logic cv = 1'b0, rr = 1'b0;
   logic [3:0] cmd_r = 4'h0;
   logic [7:0] opa_r = 8'h00, opb_r = 8'h00;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer_if bus0();
   alu_cmd_sequencer_if bus1();

   alu_cmd_sequencer #(.RESV_ERR(U0_RESV), .FAST_RET(U0_FAST)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus0));
   alu_cmd_sequencer #(.RESV_ERR(U1_RESV), .FAST_RET(U1_FAST)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus1));

   assign bus0.cmd_valid = cv && !sel;
   assign bus1.cmd_valid = cv && sel;
   assign bus0.res_ready = rr && !sel;
   assign bus1.res_ready = rr && sel;
   assign bus0.cmd = cmd_r;
   assign bus1.cmd = cmd_r;
   assign bus0.opa = opa_r;
   assign bus1.opa = opa_r;
   assign bus0.opb = opb_r;
   assign bus1.opb = opb_r;

   // ALU environment: combinational Y, registered C/V/Z/N
   typedef struct packed { logic [7:0] y; logic c, v, z, n; } alu_t;

   function automatic alu_t alu_f(input logic [15:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] f);
      alu_t r; logic [7:0] bo, lg, sh; logic [8:0] sum; logic sc;
      bo = op[1] ? b : 8'h00;
      if (!op[0]) bo = ~bo;
      sum = {1'b0, a} + {1'b0, bo} + {8'h00, f[3]};
      case (op[1:0])
         2'b00:   lg = a & b;
         2'b01:   lg = a | b;
         default: lg = a ^ b;
      endcase
      sh = a; sc = f[3];
      case (op[5:3])
         3'd1: begin sh = {a[6:0], 1'b0};  sc = a[7]; end
         3'd3: begin sh = {1'b0, a[7:1]};  sc = a[0]; end
         3'd4: begin sh = {a[6:0], f[3]};  sc = a[7]; end
         3'd5: begin sh = {f[3], a[7:1]};  sc = a[0]; end
         default: ;
      endcase
      r.y = (op[5:3] != 3'd0) ? sh : (op[2] ? lg : sum[7:0]);
      r.c = f[3]; r.v = f[2]; r.z = f[1]; r.n = f[0];
      if (op[8]) begin
         case (op[7:6])
            2'b00: r.c = sum[8];
            2'b01: r.c = sc;
            2'b10: r.c = 1'b0;
            default: r.c = 1'b1;
         endcase
      end
      if (op[11]) r.v = (op[10:9] == 2'b00) ? ((a[7] == bo[7]) && (sum[7] != a[7])) : 1'b0;
      if (op[13:12] == 2'b01) r.z = (r.y == 8'h00);
      if (op[15:14] == 2'b01) r.n = r.y[7];
      return r;
   endfunction

   logic [3:0] af0 = 4'h0, af1 = 4'h0;
   alu_t ar0, ar1;
   always_comb ar0 = alu_f(bus0.alu_op, bus0.alu_a, bus0.alu_b, af0);
   always_comb ar1 = alu_f(bus1.alu_op, bus1.alu_a, bus1.alu_b, af1);
   always @(posedge clk) begin
      af0 <= {ar0.c, ar0.v, ar0.z, ar0.n};
      af1 <= {ar1.c, ar1.v, ar1.z, ar1.n};
   end
   assign bus0.alu_y = ar0.y;
   assign bus1.alu_y = ar1.y;
   assign bus0.alu_c = af0[3];
   assign bus1.alu_c = af1[3];

   logic o_cmd_ready, o_res_valid, o_res_err;
   logic [7:0] o_res_y, o_alu_a, o_alu_b;
   logic [15:0] o_alu_op;
   logic [3:0] o_flags;
   always_comb begin
      o_cmd_ready = sel ? bus1.cmd_ready : bus0.cmd_ready;
      o_res_valid = sel ? bus1.res_valid : bus0.res_valid;
      o_res_err   = sel ? bus1.res_err   : bus0.res_err;
      o_res_y     = sel ? bus1.res_y     : bus0.res_y;
      o_alu_a     = sel ? bus1.alu_a     : bus0.alu_a;
      o_alu_b     = sel ? bus1.alu_b     : bus0.alu_b;
      o_alu_op    = sel ? bus1.alu_op    : bus0.alu_op;
      o_flags     = sel ? af1            : af0;
   end

   // command-level reference: result and flags straight from the instruction semantics
   typedef struct packed { logic [7:0] y; logic err, c, v, z, n; } ref_t;
   logic rc[2], rv[2], rz[2], rn[2];

   function automatic ref_t ref_model(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input logic v, input logic z, input logic n,
                                      input logic resv);
      ref_t r; int t, s, ia, ib, sa, sb; logic upd;
      ia = int'(a); ib = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
      r.y = a; r.err = 1'b0; r.c = c; r.v = v; r.z = z; r.n = n; upd = 1'b0; t = 0; s = 0;
      case (cmd)
         4'h0: begin t = ia + ib + int'(c); s = sa + sb + int'(c);
                     r.y = t[7:0]; r.c = (t > 255); r.v = (s > 127) || (s < -128); upd = 1'b1; end
         4'h1: begin t = ia - ib - int'(!c); s = sa - sb - int'(!c);
                     r.y = t[7:0]; r.c = (t >= 0); r.v = (s > 127) || (s < -128); upd = 1'b1; end
         4'h2: begin r.y = a & b; upd = 1'b1; end
         4'h3: begin r.y = a | b; upd = 1'b1; end
         4'h4: begin r.y = a ^ b; upd = 1'b1; end
         4'h5: begin t = ia * 2; r.y = t[7:0]; r.c = a[7]; upd = 1'b1; end
         4'h6: begin t = ia / 2; r.y = t[7:0]; r.c = a[0]; upd = 1'b1; end
         4'h7: begin t = ia * 2 + int'(c); r.y = t[7:0]; r.c = a[7]; upd = 1'b1; end
         4'h8: begin t = ia / 2 + 128 * int'(c); r.y = t[7:0]; r.c = a[0]; upd = 1'b1; end
         4'h9: begin t = ia - ib; r.c = (t >= 0); r.z = (t == 0); r.n = t[7]; end
         4'hA: begin t = ia + 1; r.y = t[7:0]; upd = 1'b1; end
         4'hB: begin t = ia - 1; r.y = t[7:0]; upd = 1'b1; end
         4'hC: r.c = 1'b0;
         4'hD: r.c = 1'b1;
         4'hE: r.v = 1'b0;
         default: r.err = resv;
      endcase
      if (upd) begin r.z = (r.y == 8'h00); r.n = r.y[7]; end
      return r;
   endfunction

   function automatic int nsteps(input logic [3:0] cmd);
      if (cmd == 4'h9) return 2;
      if (cmd == 4'hA || cmd == 4'hB) return 3;
      if (cmd == 4'hF) return 0;
      return 1;
   endfunction

   function automatic logic [15:0] ref_word(input logic [3:0] cmd, input int k, input logic cb);
      logic [15:0] w [16][3];
      w[0]  = '{16'h5903, 16'h0, 16'h0};  w[1]  = '{16'h5902, 16'h0, 16'h0};
      w[2]  = '{16'h5004, 16'h0, 16'h0};  w[3]  = '{16'h5005, 16'h0, 16'h0};
      w[4]  = '{16'h5006, 16'h0, 16'h0};  w[5]  = '{16'h514C, 16'h0, 16'h0};
      w[6]  = '{16'h515C, 16'h0, 16'h0};  w[7]  = '{16'h5164, 16'h0, 16'h0};
      w[8]  = '{16'h516C, 16'h0, 16'h0};  w[9]  = '{16'h01C0, 16'h5102, 16'h0};
      w[10] = '{16'h01C0, 16'h5001, cb ? 16'h01C0 : 16'h0180};
      w[11] = '{16'h0180, 16'h5000, cb ? 16'h01C0 : 16'h0180};
      w[12] = '{16'h0180, 16'h0, 16'h0};  w[13] = '{16'h01C0, 16'h0, 16'h0};
      w[14] = '{16'h0C00, 16'h0, 16'h0};  w[15] = '{16'h0, 16'h0, 16'h0};
      return w[cmd][k];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_cmd(input logic s, input logic [3:0] c_cmd, input logic [7:0] a,
                          input logic [7:0] b, input int hold,
                          output logic [7:0] y_o, output logic [3:0] f_o, output logic err_o);
      ref_t r; int n, w; logic cb;
      @(negedge clk);
      sel = s; cv = 1'b1; cmd_r = c_cmd; opa_r = a; opb_r = b;
      #1;
      w = 0;
      while (!o_cmd_ready && w < 20) begin @(negedge clk); #1; w++; end
      check("accept_ready", 32'(o_cmd_ready), 32'd1);
      cb = rc[s];
      r = ref_model(c_cmd, a, b, rc[s], rv[s], rz[s], rn[s], s ? U1_RESV : U0_RESV);
      n = nsteps(c_cmd);
      @(posedge clk); #1;
      cv = 1'b0; cmd_r = 4'($urandom); opa_r = 8'($urandom); opb_r = 8'($urandom);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("exec_op", 32'(o_alu_op), 32'(ref_word(c_cmd, k, cb)));
         check("exec_a", 32'(o_alu_a), 32'(a));
         check("exec_b", 32'(o_alu_b), (c_cmd >= 4'h5 && c_cmd <= 4'h8) ? 32'hFF : 32'(b));
         check("exec_busy", 32'({o_res_valid, o_cmd_ready}), 32'd0);
      end
      @(negedge clk);
      check("resp_valid", 32'(o_res_valid), 32'd1);
      check("resp_y", 32'(o_res_y), 32'(r.y));
      check("resp_err", 32'(o_res_err), 32'(r.err));
      check("resp_op", 32'(o_alu_op), 32'd0);
      check("resp_flags", 32'(o_flags), 32'({r.c, r.v, r.z, r.n}));
      y_o = o_res_y; f_o = o_flags; err_o = o_res_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_y", 32'(o_res_y), 32'(r.y));
         check("hold_state", 32'({o_res_valid, o_cmd_ready, o_alu_op}), 32'h20000);
      end
      rr = 1'b1; #1;
      check("ret_ready", 32'(o_cmd_ready), s ? 32'(U1_FAST) : 32'(U0_FAST));
      @(posedge clk); #1; rr = 1'b0;
      @(negedge clk);
      check("idle", 32'({o_res_valid, o_cmd_ready}), 32'd1);
      rc[s] = r.c; rv[s] = r.v; rz[s] = r.z; rn[s] = r.n;
   endtask

   typedef struct {
      logic s; logic [3:0] cmd; logic [7:0] a, b; logic cin; int hold;
      logic [7:0] y; logic err, c, v, zn, z, n;
   } vec_t;
   vec_t tv [23];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] y; logic [3:0] f; logic e; ref_t r;
      tv = '{
         '{1'b0,4'h0,8'h50,8'h50,1'b0,0,8'hA0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1},
         '{1'b0,4'h0,8'hFF,8'h01,1'b0,0,8'h00,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0},
         '{1'b0,4'h1,8'h50,8'h30,1'b1,0,8'h20,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0},
         '{1'b0,4'h1,8'h00,8'h01,1'b1,0,8'hFF,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1},
         '{1'b0,4'h1,8'h80,8'h01,1'b1,0,8'h7F,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0},
         '{1'b0,4'h2,8'hF0,8'h3C,1'b1,0,8'h30,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0},
         '{1'b0,4'h3,8'h0F,8'h80,1'b0,0,8'h8F,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1},
         '{1'b0,4'h4,8'hFF,8'hFF,1'b1,0,8'h00,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0},
         '{1'b0,4'h5,8'h81,8'h00,1'b0,0,8'h02,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0},
         '{1'b0,4'h6,8'h01,8'h00,1'b1,0,8'h00,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0},
         '{1'b0,4'h7,8'h80,8'h00,1'b1,0,8'h01,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0},
         '{1'b0,4'h8,8'h01,8'h00,1'b1,5,8'h80,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1},
         '{1'b0,4'h9,8'h10,8'h20,1'b1,0,8'h10,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1},
         '{1'b0,4'h9,8'h20,8'h20,1'b0,0,8'h20,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0},
         '{1'b0,4'hA,8'hFF,8'h00,1'b0,0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0},
         '{1'b0,4'hA,8'hFF,8'h00,1'b1,0,8'h00,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0},
         '{1'b0,4'hB,8'h00,8'h00,1'b0,0,8'hFF,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1},
         '{1'b0,4'hB,8'h80,8'h00,1'b1,0,8'h7F,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0},
         '{1'b0,4'hC,8'h44,8'h00,1'b1,0,8'h44,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
         '{1'b0,4'hD,8'h00,8'h00,1'b0,0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0},
         '{1'b0,4'hF,8'h33,8'h00,1'b1,0,8'h33,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0},
         '{1'b1,4'hF,8'h77,8'h00,1'b0,2,8'h77,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
         '{1'b1,4'h0,8'h7F,8'h01,1'b1,0,8'h81,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1}
      };
      for (int i = 0; i < 2; i++) begin rc[i] = 1'b0; rv[i] = 1'b0; rz[i] = 1'b0; rn[i] = 1'b0; end

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", 32'({o_cmd_ready, o_res_valid, o_res_err, o_res_y}), 32'h400);
      check("rst_alu", {o_alu_a, o_alu_b, o_alu_op}, 32'd0);
      rst_n = 1'b1;

      foreach (tv[i]) begin
         run_cmd(tv[i].s, 4'hE, 8'h00, 8'h00, 0, y, f, e);
         run_cmd(tv[i].s, tv[i].cin ? 4'hD : 4'hC, 8'h00, 8'h00, 0, y, f, e);
         run_cmd(tv[i].s, tv[i].cmd, tv[i].a, tv[i].b, tv[i].hold, y, f, e);
         check($sformatf("vec%0d_y", i), 32'(y), 32'(tv[i].y));
         check($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].err));
         check($sformatf("vec%0d_cv", i), 32'(f[3:2]), 32'({tv[i].c, tv[i].v}));
         if (tv[i].zn) check($sformatf("vec%0d_zn", i), 32'(f[1:0]), 32'({tv[i].z, tv[i].n}));
      end

      for (int i = 0; i < 80; i++)
         run_cmd($urandom_range(0, 3) == 0, 4'($urandom), 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 2)), y, f, e);

      // back-to-back on the FAST_RET instance: reserved NOP then ADC in the handshake cycle
      @(negedge clk);
      sel = 1'b1; cv = 1'b1; cmd_r = 4'hF; opa_r = 8'h5A;
      @(posedge clk); #1; cv = 1'b0;
      @(negedge clk);
      check("b2b_resv", 32'({o_res_valid, o_res_err, o_res_y}), 32'h25A);
      check("b2b_resv_op", 32'(o_alu_op), 32'd0);
      cv = 1'b1; cmd_r = 4'h0; opa_r = 8'h01; opb_r = 8'h02; rr = 1'b1; #1;
      check("b2b_ready", 32'(o_cmd_ready), 32'd1);
      r = ref_model(4'h0, 8'h01, 8'h02, rc[1], rv[1], rz[1], rn[1], U1_RESV);
      @(posedge clk); #1; cv = 1'b0; rr = 1'b0;
      @(negedge clk);
      check("b2b_exec", 32'({o_res_valid, o_alu_op}), 32'h05903);
      @(negedge clk);
      check("b2b_resp", 32'({o_res_valid, o_res_y}), 32'({1'b1, r.y}));
      check("b2b_flags", 32'(o_flags), 32'({r.c, r.v, r.z, r.n}));
      rr = 1'b1;
      @(posedge clk); #1; rr = 1'b0;
      rc[1] = r.c; rv[1] = r.v; rz[1] = r.z; rn[1] = r.n;

      // reset in the middle of INC: only the carry-set step reached the ALU
      @(negedge clk);
      sel = 1'b0; cv = 1'b1; cmd_r = 4'hA; opa_r = 8'h12; opb_r = 8'h00;
      @(posedge clk); #1; cv = 1'b0;
      @(negedge clk);
      check("rst_mid_step0", 32'(o_alu_op), 32'h01C0);
      @(negedge clk);
      check("rst_mid_step1", 32'(o_alu_op), 32'h5001);
      rst_n = 1'b0; #1;
      check("rst_mid_op", {o_alu_op, o_alu_a, o_alu_b}, 32'd0);
      check("rst_mid_out", 32'({o_cmd_ready, o_res_valid, o_res_err, o_res_y}), 32'h400);
      rc[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; #1;
      check("rst_rel_ready", 32'(o_cmd_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_rel_idle", 32'({o_res_valid, o_alu_op}), 32'd0);
      end
      check("rst_carry", 32'(af0[3]), 32'(rc[0]));
      run_cmd(1'b0, 4'h0, 8'h0F, 8'h01, 0, y, f, e);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
